// File: rtl/acs_unit.sv
// Add-compare-select stage of a K=3 rate-1/2 hard-decision Viterbi decoder (7/5 octal).
// Latency is one cycle and every cycle can accept a symbol; there is no backpressure.
module acs_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] symbol_in,
    input  logic       symbol_valid,
    output logic [3:0] new_branch_metric_00,
    output logic [3:0] new_branch_metric_01,
    output logic [3:0] new_branch_metric_10,
    output logic [3:0] new_branch_metric_11,
    output logic [7:0] updated_selected_branch_at_00,
    output logic [7:0] updated_selected_branch_at_01,
    output logic [7:0] updated_selected_branch_at_10,
    output logic [7:0] updated_selected_branch_at_11,
    output logic [2:0] write_pointer_out,
    output logic       valid_out
);

    logic [3:0] r_pm     [4];
    logic [7:0] r_surv   [4];
    logic [2:0] r_wp;
    logic [2:0] r_wp_out;
    logic       r_valid;

    logic [3:0] w_base_pm   [4];
    logic [7:0] w_base_surv [4];
    logic [2:0] w_wp;
    logic [4:0] w_sel_pm    [4];
    logic [7:0] w_new_surv  [4];
    logic [4:0] w_diff      [4];
    logic [3:0] w_norm_pm   [4];
    logic [4:0] w_min_lo;
    logic [4:0] w_min_hi;
    logic [4:0] w_min;

    function automatic logic [1:0] hamming(input logic [1:0] sym, input logic [1:0] expct);
        logic [1:0] d;
        d = sym ^ expct;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    // A start in the same cycle as a symbol makes the symbol see the freshly initialised frame.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            w_base_pm[s]   = start ? ((s == 0) ? 4'd0 : 4'd7) : r_pm[s];
            w_base_surv[s] = start ? 8'd0 : r_surv[s];
        end
        w_wp = start ? 3'd0 : r_wp;
    end

    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam logic U  = (g >= 2);
        localparam logic A  = ((g % 2) == 1);
        localparam int   P0 = (g % 2) * 2;
        localparam int   P1 = P0 + 1;

        logic [4:0] w_cand0;
        logic [4:0] w_cand1;
        logic       w_pick1;
        logic [7:0] w_surv;

        assign w_cand0 = {1'b0, w_base_pm[P0]} + {3'b000, hamming(symbol_in, {U ^ A, U})};
        assign w_cand1 = {1'b0, w_base_pm[P1]} + {3'b000, hamming(symbol_in, {~(U ^ A), ~U})};
        // Strict compare: a tie keeps the b=0 predecessor.
        assign w_pick1 = (w_cand1 < w_cand0);
        assign w_sel_pm[g] = w_pick1 ? w_cand1 : w_cand0;

        always_comb begin
            w_surv       = w_pick1 ? w_base_surv[P1] : w_base_surv[P0];
            w_surv[w_wp] = U;
        end
        assign w_new_surv[g] = w_surv;
    end

    assign w_min_lo = (w_sel_pm[1] < w_sel_pm[0]) ? w_sel_pm[1] : w_sel_pm[0];
    assign w_min_hi = (w_sel_pm[3] < w_sel_pm[2]) ? w_sel_pm[3] : w_sel_pm[2];
    assign w_min    = (w_min_hi < w_min_lo) ? w_min_hi : w_min_lo;

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            w_diff[s]    = w_sel_pm[s] - w_min;
            w_norm_pm[s] = (w_diff[s] > 5'd15) ? 4'd15 : w_diff[s][3:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 4; s++) begin
                r_pm[s]   <= 4'd0;
                r_surv[s] <= 8'd0;
            end
            r_wp     <= 3'd0;
            r_wp_out <= 3'd0;
            r_valid  <= 1'b0;
        end else if (symbol_valid) begin
            for (int s = 0; s < 4; s++) begin
                r_pm[s]   <= w_norm_pm[s];
                r_surv[s] <= w_new_surv[s];
            end
            r_wp_out <= w_wp;
            r_wp     <= w_wp + 3'd1;
            r_valid  <= 1'b1;
        end else if (start) begin
            for (int s = 0; s < 4; s++) begin
                r_pm[s]   <= (s == 0) ? 4'd0 : 4'd7;
                r_surv[s] <= 8'd0;
            end
            r_wp     <= 3'd0;
            r_wp_out <= 3'd0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign new_branch_metric_00          = r_pm[0];
    assign new_branch_metric_01          = r_pm[1];
    assign new_branch_metric_10          = r_pm[2];
    assign new_branch_metric_11          = r_pm[3];
    assign updated_selected_branch_at_00 = r_surv[0];
    assign updated_selected_branch_at_01 = r_surv[1];
    assign updated_selected_branch_at_10 = r_surv[2];
    assign updated_selected_branch_at_11 = r_surv[3];
    assign write_pointer_out             = r_wp_out;
    assign valid_out                     = r_valid;

endmodule

// File: tb/tb_acs_unit.sv
// Randomised bench for acs_unit against a trellis-level reference model.
module tb_acs_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] symbol_in;
    logic       symbol_valid;
    logic [3:0] m00, m01, m10, m11;
    logic [7:0] s00, s01, s10, s11;
    logic [2:0] wp_out;
    logic       vld;

    int vectors = 0;
    int errors  = 0;

    acs_unit dut (
        .clk                           (clk),
        .rst                           (rst),
        .start                         (start),
        .symbol_in                     (symbol_in),
        .symbol_valid                  (symbol_valid),
        .new_branch_metric_00          (m00),
        .new_branch_metric_01          (m01),
        .new_branch_metric_10          (m10),
        .new_branch_metric_11          (m11),
        .updated_selected_branch_at_00 (s00),
        .updated_selected_branch_at_01 (s01),
        .updated_selected_branch_at_10 (s10),
        .updated_selected_branch_at_11 (s11),
        .write_pointer_out             (wp_out),
        .valid_out                     (vld)
    );

    always #5 clk = ~clk;

    wire [51:0] dut_vec = {m00, m01, m10, m11, s00, s01, s10, s11, wp_out, vld};
    logic [3:0] dpm [4];
    logic [7:0] dsv [4];
    assign dpm[0] = m00; assign dpm[1] = m01; assign dpm[2] = m10; assign dpm[3] = m11;
    assign dsv[0] = s00; assign dsv[1] = s01; assign dsv[2] = s10; assign dsv[3] = s11;

    // Reference model: path metrics, survivors, pointer and valid as plain integers/arrays.
    int         mpm [4];
    logic [7:0] msv [4];
    int         mwp, mwpo;
    bit         mval;
    logic [1:0] enc_s;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin mpm[i] = 0; msv[i] = 8'd0; end
        mwp = 0; mwpo = 0; mval = 0;
    endfunction

    function automatic void model_apply(bit st, bit v, logic [1:0] sym);
        int         nm [4];
        logic [7:0] nsv [4];
        int         mn;
        if (st) begin
            mpm[0] = 0; mpm[1] = 7; mpm[2] = 7; mpm[3] = 7;
            for (int i = 0; i < 4; i++) msv[i] = 8'd0;
            mwp = 0; mwpo = 0;
        end
        if (v) begin
            for (int ns = 0; ns < 4; ns++) begin
                int u;
                int a;
                int best;
                u = ns / 2; a = ns % 2; best = -1;
                for (int b = 0; b < 2; b++) begin
                    int         p;
                    int         c;
                    logic [1:0] expo;
                    p    = a * 2 + b;
                    expo = {1'((u ^ a ^ b) & 1), 1'((u ^ b) & 1)};
                    c    = mpm[p] + $countones(expo ^ sym);
                    if (best < 0 || c < best) begin best = c; nsv[ns] = msv[p]; end
                end
                nsv[ns][mwp] = (u == 1);
                nm[ns] = best;
            end
            mn = nm[0];
            for (int i = 1; i < 4; i++) if (nm[i] < mn) mn = nm[i];
            for (int i = 0; i < 4; i++) begin
                mpm[i] = (nm[i] - mn > 15) ? 15 : nm[i] - mn;
                msv[i] = nsv[i];
            end
            mwpo = mwp;
            mwp  = (mwp + 1) % 8;
            mval = 1;
        end else begin
            mval = 0;
        end
    endfunction

    function automatic logic [51:0] model_vec();
        return {4'(mpm[0]), 4'(mpm[1]), 4'(mpm[2]), 4'(mpm[3]),
                msv[0], msv[1], msv[2], msv[3], 3'(mwpo), mval};
    endfunction

    // Convolutional encoder g0 = u^s1^s0, g1 = u^s0, state {s1,s0} = {u[n-1],u[n-2]}.
    function automatic logic [1:0] encode(bit u);
        logic [1:0] sym;
        sym   = {u ^ enc_s[1] ^ enc_s[0], u ^ enc_s[0]};
        enc_s = {u, enc_s[1]};
        return sym;
    endfunction

    task automatic drive(input bit st, input bit v, input logic [1:0] sym);
        @(negedge clk);
        start = st; symbol_valid = v; symbol_in = sym;
        @(posedge clk);
        model_apply(st, v, sym);
        #1;
        start = 1'b0; symbol_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; symbol_valid = 1'b0; symbol_in = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (dut_vec !== 52'd0) begin errors++; $display("FAIL reset_init: got %h expected 0", dut_vec); end
        @(negedge clk); rst = 1'b0;
        drive(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 2'($urandom_range(0, 3)));
            vectors++;
            if (dut_vec !== model_vec()) begin errors++; $display("FAIL reset_pre step %0d: got %h expected %h", i, dut_vec, model_vec()); end
        end
        @(negedge clk); rst = 1'b1; symbol_valid = 1'b1; symbol_in = 2'($urandom_range(0, 3));
        #1;
        vectors++;
        if (dut_vec !== 52'd0) begin errors++; $display("FAIL reset_async: got %h expected 0", dut_vec); end
        @(posedge clk); #1;
        vectors++;
        if (dut_vec !== 52'd0) begin errors++; $display("FAIL reset_hold: got %h expected 0", dut_vec); end
        model_reset();
        @(negedge clk); rst = 1'b0; symbol_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 2'b00);
            vectors++;
            if (vld !== 1'b0) begin errors++; $display("FAIL reset_idle_valid step %0d: got %b expected 0", i, vld); end
        end
        drive(1'b0, 1'b1, 2'($urandom_range(0, 3)));
        vectors++;
        if (wp_out !== 3'd0 || vld !== 1'b1) begin errors++; $display("FAIL reset_first_wp: got wp %0d valid %b expected wp 0 valid 1", wp_out, vld); end
        vectors++;
        if (dut_vec !== model_vec()) begin errors++; $display("FAIL reset_first_update: got %h expected %h", dut_vec, model_vec()); end
    endtask

    task automatic test_start_symbol();
        drive(1'b1, 1'b1, 2'b00);
        vectors++;
        if ({m00, m01, m10, m11} !== 16'h0828) begin errors++; $display("FAIL start_sym_metrics: got %h expected 0828", {m00, m01, m10, m11}); end
        vectors++;
        if ({s00, s01, s10, s11} !== 32'h00000101) begin errors++; $display("FAIL start_sym_surv: got %h expected 00000101", {s00, s01, s10, s11}); end
        vectors++;
        if (wp_out !== 3'd0 || vld !== 1'b1) begin errors++; $display("FAIL start_sym_wp: got wp %0d valid %b expected wp 0 valid 1", wp_out, vld); end
        vectors++;
        if (dut_vec !== model_vec()) begin errors++; $display("FAIL start_sym_model: got %h expected %h", dut_vec, model_vec()); end
    endtask

    task automatic test_error_free();
        bit bits [4];
        bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1; bits[3] = 1'b1;
        drive(1'b1, 1'b0, 2'b00);
        vectors++;
        if (vld !== 1'b0 || {m00, m01, m10, m11} !== 16'h0777 || wp_out !== 3'd0) begin
            errors++; $display("FAIL start_only: got valid %b metrics %h wp %0d expected 0 0777 0", vld, {m00, m01, m10, m11}, wp_out);
        end
        enc_s = 2'b00;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, encode(bits[i]));
            vectors++;
            if (dut_vec !== model_vec()) begin errors++; $display("FAIL error_free step %0d: got %h expected %h", i, dut_vec, model_vec()); end
        end
        vectors++;
        if (m11 !== 4'd0 || s11[3:0] !== 4'b1101 || wp_out !== 3'd3) begin
            errors++; $display("FAIL error_free_end: got m11 %0d surv11 %b wp %0d expected 0 1101 3", m11, s11[3:0], wp_out);
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, 2'($urandom_range(0, 3)));
            vectors++;
            if (wp_out !== 3'(i % 8)) begin errors++; $display("FAIL wrap_wp step %0d: got %0d expected %0d", i, wp_out, i % 8); end
            vectors++;
            if (dut_vec !== model_vec()) begin errors++; $display("FAIL wrap_model step %0d: got %h expected %h", i, dut_vec, model_vec()); end
        end
        for (int ns = 0; ns < 4; ns++) begin
            vectors++;
            if (dsv[ns][0] !== (ns >= 2)) begin errors++; $display("FAIL wrap_bit0 state %0d: got %b expected %b", ns, dsv[ns][0], ns >= 2); end
        end
    endtask

    task automatic test_normalisation();
        drive(1'b1, 1'b0, 2'b00);
        enc_s = 2'b00;
        for (int i = 0; i < 64; i++) begin
            logic [1:0] sym;
            int         mn;
            sym = encode(1'($urandom_range(0, 1)));
            sym = sym ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
            drive(1'b0, 1'b1, sym);
            mn = dpm[0];
            for (int s = 1; s < 4; s++) if (dpm[s] < mn) mn = dpm[s];
            vectors++;
            if (mn != 0) begin errors++; $display("FAIL norm_min step %0d: got %0d expected 0", i, mn); end
            vectors++;
            if (dut_vec !== model_vec()) begin errors++; $display("FAIL norm_model step %0d: got %h expected %h", i, dut_vec, model_vec()); end
        end
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 2'($urandom_range(0, 3)));
            vectors++;
            if (vld !== 1'b1 || dut_vec !== model_vec()) begin errors++; $display("FAIL gap_update %0d: got %h expected %h", i, dut_vec, model_vec()); end
            for (int g = 0; g < 3; g++) begin
                drive(1'b0, 1'b0, 2'($urandom_range(0, 3)));
                vectors++;
                if (vld !== 1'b0 || dut_vec !== model_vec()) begin errors++; $display("FAIL gap_hold %0d.%0d: got %h expected %h", i, g, dut_vec, model_vec()); end
            end
        end
    endtask

    task automatic test_start_midframe();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 2'($urandom_range(0, 3)));
        drive(1'b1, 1'b1, 2'($urandom_range(0, 3)));
        vectors++;
        if (wp_out !== 3'd0 || vld !== 1'b1) begin errors++; $display("FAIL midframe_wp: got wp %0d valid %b expected wp 0 valid 1", wp_out, vld); end
        vectors++;
        if (dut_vec !== model_vec()) begin errors++; $display("FAIL midframe_model: got %h expected %h", dut_vec, model_vec()); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 120; i++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
            vectors++;
            if (dut_vec !== model_vec()) begin errors++; $display("FAIL random step %0d: got %h expected %h", i, dut_vec, model_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_start_symbol();
        test_error_free();
        test_wrap();
        test_normalisation();
        test_gaps();
        test_start_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/acs_unit.md
# acs_unit

Add-compare-select stage of the K=3, rate-1/2 hard-decision Viterbi decoder (generators 7/5 octal). It sits directly upstream of the path selector. It accepts one received 2-bit code symbol per valid cycle and updates four normalised 4-bit path metrics and four 8-bit survivor registers. It presents them, with the write pointer used and a one-cycle valid pulse, in exactly the form the selector consumes.

## Interface
- No parameters. Constraint length, metric width (4), survivor depth (8) and pointer width (3) are fixed.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  frame start: reinitialise metrics, survivors and pointer (see Operation).
- symbol_in  in  2  received symbol {g0,g1}; g0 = u^s1^s0, g1 = u^s0.
- symbol_valid  in  1  symbol_in is valid this cycle; no backpressure.
- new_branch_metric_00/01/10/11  out  4 each  normalised path metric per state.
- updated_selected_branch_at_00/01/10/11  out  8 each  survivor bits per state.
- write_pointer_out  out  3  survivor bit position written by the update just presented.
- valid_out  out  1  one-cycle pulse: the outputs above were updated last edge.

## Operation
- State s = {s1,s0} = {u[n-1],u[n-2]}. Next state ns = {u, s1}. Predecessors of ns = {u,a} are {a,0} (b=0) and {a,1} (b=1). Branch output is {u^a^b, u^b}.
- Transitions and expected outputs:
  - ns00: from 00/00 and from 01/11.
  - ns01: from 10/10 and from 11/01.
  - ns10: from 00/11 and from 01/00.
  - ns11: from 10/01 and from 11/10.
- Branch metric is the Hamming distance between symbol_in and the expected output, 0..2.
- Candidate = pm(pred) + bm, computed 5 bits wide. Select the smaller candidate. On a tie, select the b=0 predecessor.
- Normalise: subtract the minimum of the four selected values from each, then saturate to 15. After every update at least one metric is 0.
- Survivor for ns is a copy of the selected predecessor's survivor, with bit[wp] replaced by u = ns[1]. All other bits are copied unchanged.
- Internal wp starts at 0 and increments by 1 per accepted symbol, wrapping 7->0. write_pointer_out holds the wp value used for the presented update.
- Outputs are the state registers themselves. They hold their values while symbol_valid = 0.
- start initialises the state:
  - Metrics become {00:0, 01:7, 10:7, 11:7}.
  - Survivors become 0 and wp becomes 0.
  - write_pointer_out becomes 0.
  - valid_out = 0, unless a symbol is also accepted that cycle.
- start and symbol_valid in the same cycle: the symbol is processed against the initialised values (first symbol of the frame). valid_out = 1 next cycle, and write_pointer_out = 0.

## Timing
- Reset values: all metrics 0, all survivors 0, write_pointer_out 0, valid_out 0, internal wp 0.
- Latency is 1 cycle. The symbol sampled at edge N produces updated outputs and valid_out = 1 after edge N, for exactly one cycle.
- Full throughput: back-to-back symbols give back-to-back valid_out pulses.
- Gaps in symbol_valid give valid_out = 0, with outputs and wp unchanged.
- Reset asserted mid-frame returns every register to its reset value immediately. The first update after release uses wp = 0.

## Test plan
- Reset check: assert rst mid-stream. All outputs must read 0 while reset is asserted, and valid_out must stay 0 after release until the first symbol.
- start + symbol 00 in the same cycle. Next cycle requires:
  - Metrics 00=0, 01=8, 10=2, 11=8.
  - Survivors 00=0x00, 01=0x00 (tie, pred 10), 10=0x01, 11=0x01.
  - write_pointer_out = 0 and valid_out = 1.
- Error-free sequence after start: info bits 1,0,1,1 encode to symbols 11,10,00,01. After the fourth symbol:
  - new_branch_metric_11 = 0.
  - updated_selected_branch_at_11[3:0] = 4'b1101.
  - write_pointer_out = 3.
- Wrap-around: 9 consecutive symbols give write_pointer_out = 0,1,...,7,0. On the ninth update, bit0 of each survivor must be rewritten, with bits 7:1 copied from the predecessor.
- Normalisation: 64 random symbols, each with one injected bit error. On every valid_out, min metric = 0 and every metric ≤ 15. Results must match a reference model.
- Idle gaps and stimulus-scoreboard checks:
  - Symbols with 3-cycle symbol_valid gaps: valid_out pulses once per symbol, and outputs are stable during gaps.
  - One-shot: same-cycle start + symbol mid-frame must reinitialise before processing.
